// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential-divider front panel controller.
// DIV_REM_DISPLAY_EN adds the REM display state.
package div_pkg;

  localparam int unsigned W_DEFAULT       = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_NUM  = 3'd0,
    S_DEN  = 3'd1,
    S_RUN  = 3'd2,
    S_QUOT = 3'd3,
`ifdef DIV_REM_DISPLAY_EN
    S_REM  = 3'd4,
`endif
    S_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Controller <-> divider datapath handshake: start/operands out, done/results back.
interface div_seq_ctrl_if #(
  parameter int unsigned W = div_pkg::W_DEFAULT
);
  logic         dp_start;
  logic [W-1:0] dp_num;
  logic [W-1:0] dp_den;
  logic         dp_done;
  logic [W-1:0] dp_quot;
  logic [W-1:0] dp_rem;

  modport master (output dp_start, dp_num, dp_den, input dp_done, dp_quot, dp_rem);
  modport slave  (input dp_start, dp_num, dp_den, output dp_done, dp_quot, dp_rem);
endinterface

// File: rtl/div_seq_ctrl_btn_sync.sv
// Two-flop synchronizer for an active-low pushbutton plus a one-cycle press pulse
// on the synchronized 1->0 transition.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_c
);
  logic meta, sync, prev;

  // Reset to "released" so deasserting reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign press_c = prev & ~sync;
endmodule

// File: rtl/div_seq_ctrl.sv
// Pushbutton front panel for a sequential divider: edit operands, launch, show results.
// DIV_REM_DISPLAY_EN enables the remainder display step after the quotient.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          ok,
  output logic [W-1:0]  leds,
  div_seq_ctrl_if.master dp
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t         state, next_state;
  logic [W-1:0]   edit, edit_d;
  logic [W-1:0]   num_d, den_d;
  logic [W-1:0]   quot, quot_d;
  logic [W-1:0]   leds_d;
  logic           start_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           up_p, down_p, ok_p;
`ifdef DIV_REM_DISPLAY_EN
  logic [W-1:0]   rem, rem_d;
`else
  logic           unused_rem;
  assign unused_rem = ^dp.dp_rem;
`endif

  btn_sync u_up   (.clk(clk), .rst(rst), .btn(up),   .press_c(up_p));
  btn_sync u_down (.clk(clk), .rst(rst), .btn(down), .press_c(down_p));
  btn_sync u_ok   (.clk(clk), .rst(rst), .btn(ok),   .press_c(ok_p));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_NUM;
    else     state <= next_state;
  end

  // Next state; ok outranks up/down, dp_done outranks the RUN timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_NUM:  if (ok_p) next_state = S_DEN;
      S_DEN:  if (ok_p) next_state = (edit == '0) ? S_ERR : S_RUN;
      S_RUN: begin
        if (dp.dp_done)                   next_state = S_QUOT;
        else if (cnt == CW'(TIMEOUT - 1)) next_state = S_ERR;
      end
`ifdef DIV_REM_DISPLAY_EN
      S_QUOT: if (ok_p) next_state = S_REM;
      S_REM:  if (ok_p) next_state = S_NUM;
`else
      S_QUOT: if (ok_p) next_state = S_NUM;
`endif
      S_ERR:  if (ok_p) next_state = S_NUM;
      default: next_state = S_NUM;
    endcase
  end

  // Next values of the edit register, operands, captures, counter and display.
  always_comb begin
    edit_d  = edit;
    num_d   = dp.dp_num;
    den_d   = dp.dp_den;
    quot_d  = quot;
    start_d = 1'b0;
    cnt_d   = '0;
    leds_d  = '0;
`ifdef DIV_REM_DISPLAY_EN
    rem_d   = rem;
`endif
    case (state)
      S_NUM, S_DEN: begin
        if (ok_p) begin
          edit_d = '0;
          if (state == S_NUM) begin
            num_d = edit;
          end else if (edit != '0) begin
            den_d   = edit;
            start_d = 1'b1;
          end
        end else if (up_p && !down_p) begin
          edit_d = edit + W'(1);
        end else if (down_p && !up_p) begin
          edit_d = edit - W'(1);
        end
      end
      S_RUN: begin
        if (dp.dp_done) begin
          quot_d = dp.dp_quot;
`ifdef DIV_REM_DISPLAY_EN
          rem_d  = dp.dp_rem;
`endif
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: ;
    endcase
    if (next_state == S_NUM && state != S_NUM) edit_d = '0;

    case (next_state)
      S_NUM, S_DEN: leds_d = edit_d;
      S_QUOT:       leds_d = quot_d;
`ifdef DIV_REM_DISPLAY_EN
      S_REM:        leds_d = rem_d;
`endif
      S_ERR:        leds_d = '1;
      default:      leds_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edit        <= '0;
      quot        <= '0;
      cnt         <= '0;
      leds        <= '0;
      dp.dp_start <= 1'b0;
      dp.dp_num   <= '0;
      dp.dp_den   <= '0;
`ifdef DIV_REM_DISPLAY_EN
      rem         <= '0;
`endif
    end else begin
      edit        <= edit_d;
      quot        <= quot_d;
      cnt         <= cnt_d;
      leds        <= leds_d;
      dp.dp_start <= start_d;
      dp.dp_num   <= num_d;
      dp.dp_den   <= den_d;
`ifdef DIV_REM_DISPLAY_EN
      rem         <= rem_d;
`endif
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: button tasks, a behavioural divider
// datapath, and arithmetic expectations for edit, divide, error and timeout paths.
module tb_div_seq_ctrl;
  localparam int unsigned W       = 4;
  localparam int unsigned TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         up = 1'b1, down = 1'b1, ok = 1'b1;
  logic [W-1:0] leds;

  div_seq_ctrl_if #(.W(W)) dp ();

  div_seq_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .ok(ok), .leds(leds), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int start_cnt = 0;
  int dp_delay = 4;
  logic [W-1:0] cap_num = '0, cap_den = '0;

  // Independent dp_start pulse counter (counts every high cycle).
  initial forever begin
    @(negedge clk);
    if (dp.dp_start === 1'b1) start_cnt++;
  end

  // Divider datapath model: dp_done arrives dp_delay cycles after dp_start, 0 = never.
  initial begin
    dp.dp_done = 1'b0;
    dp.dp_quot = '0;
    dp.dp_rem  = '0;
    forever begin
      @(negedge clk);
      if (dp.dp_start === 1'b1) begin
        int d;
        d = dp_delay;
        cap_num = dp.dp_num;
        cap_den = dp.dp_den;
        if (d != 0) begin
          repeat (d - 1) @(negedge clk);
          dp.dp_quot = (cap_den == '0) ? '0 : W'(int'(cap_num) / int'(cap_den));
          dp.dp_rem  = (cap_den == '0) ? '0 : W'(int'(cap_num) % int'(cap_den));
          dp.dp_done = 1'b1;
          @(negedge clk);
          dp.dp_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic press(input bit u, input bit d, input bit o);
    @(negedge clk);
    up = ~u; down = ~d; ok = ~o;
    repeat (3) @(negedge clk);
    up = 1'b1; down = 1'b1; ok = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Holds ok until dp_start is seen; returns with the bench at that negedge.
  task automatic ok_until_start(output bit found);
    found = 1'b0;
    @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dp.dp_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    ok = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (leds !== '0 || dp.dp_start !== 1'b0 || dp.dp_num !== '0 || dp.dp_den !== '0) begin
      $display("FAIL reset_state: leds=%b start=%b num=%b den=%b required 0000 0 0000 0000",
               leds, dp.dp_start, dp.dp_num, dp.dp_den);
    end else n_pass++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if (leds !== '0) $display("FAIL reset_no_spurious: leds=%b required 0000", leds);
    else n_pass++;
  endtask

  task automatic test_edit();
    repeat (3) press(1, 0, 0);
    n_total++;
    if (leds !== W'(3)) $display("FAIL edit_up3: leds=%b required 0011", leds);
    else n_pass++;
    press(0, 1, 0);
    n_total++;
    if (leds !== W'(2)) $display("FAIL edit_down1: leds=%b required 0010", leds);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    press(0, 1, 0);
    n_total++;
    if (leds !== W'(15)) $display("FAIL wrap_down: leds=%b required 1111", leds);
    else n_pass++;
    press(1, 0, 0);
    n_total++;
    if (leds !== W'(0)) $display("FAIL wrap_up: leds=%b required 0000", leds);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int s0;
    do_reset();
    dp_delay = 4;
    repeat (7) press(1, 0, 0);
    press(1, 1, 0);
    n_total++;
    if (leds !== W'(7)) $display("FAIL up_down_same: leds=%b required 0111", leds);
    else n_pass++;
    press(1, 0, 1);
    n_total++;
    if (leds !== W'(0)) $display("FAIL ok_over_up: leds=%b required 0000", leds);
    else n_pass++;
    repeat (3) press(1, 0, 0);
    s0 = start_cnt;
    press(0, 1, 1);
    repeat (20) @(negedge clk);
    n_total++;
    if (start_cnt - s0 != 1 || cap_num !== W'(7) || cap_den !== W'(3) || leds !== W'(2)) begin
      $display("FAIL ok_over_down: starts=%0d num=%0d den=%0d leds=%b required 1 7 3 0010",
               start_cnt - s0, cap_num, cap_den, leds);
    end else n_pass++;
  endtask

  task automatic test_divide();
    int s0;
    do_reset();
    dp_delay = 4;
    s0 = start_cnt;
    repeat (9) press(1, 0, 0);
    press(0, 0, 1);
    repeat (2) press(1, 0, 0);
    press(0, 0, 1);
    repeat (20) @(negedge clk);
    n_total++;
    if (start_cnt - s0 != 1 || cap_num !== W'(9) || cap_den !== W'(2)) begin
      $display("FAIL divide_start: starts=%0d num=%0d den=%0d required 1 9 2",
               start_cnt - s0, cap_num, cap_den);
    end else n_pass++;
    n_total++;
    if (dp.dp_num !== W'(9) || dp.dp_den !== W'(2))
      $display("FAIL divide_operands_stable: num=%0d den=%0d required 9 2", dp.dp_num, dp.dp_den);
    else n_pass++;
    n_total++;
    if (leds !== W'(4)) $display("FAIL divide_quot: leds=%b required 0100", leds);
    else n_pass++;
    press(0, 0, 1);
`ifdef DIV_REM_DISPLAY_EN
    n_total++;
    if (leds !== W'(1)) $display("FAIL divide_rem: leds=%b required 0001", leds);
    else n_pass++;
    press(0, 0, 1);
`endif
    n_total++;
    if (leds !== W'(0)) $display("FAIL divide_back_to_num: leds=%b required 0000", leds);
    else n_pass++;
  endtask

  task automatic test_den_zero();
    int s0;
    do_reset();
    s0 = start_cnt;
    repeat (5) press(1, 0, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    repeat (5) @(negedge clk);
    n_total++;
    if (leds !== W'(15) || start_cnt != s0)
      $display("FAIL den_zero_err: leds=%b starts=%0d required 1111 0", leds, start_cnt - s0);
    else n_pass++;
    press(0, 0, 1);
    n_total++;
    if (leds !== W'(0)) $display("FAIL den_zero_recover: leds=%b required 0000", leds);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit found;
    do_reset();
    dp_delay = 0;
    repeat (3) press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    ok_until_start(found);
    n_total++;
    if (!found) $display("FAIL timeout_start_seen: dp_start=0 required 1 within 20 cycles");
    else n_pass++;
    for (int n = 1; n <= int'(TIMEOUT); n++) begin
      @(negedge clk);
      if (n == 1 || n == int'(TIMEOUT) - 1) begin
        n_total++;
        if (leds !== W'(0)) $display("FAIL timeout_run_cycle%0d: leds=%b required 0000", n, leds);
        else n_pass++;
      end
    end
    n_total++;
    if (leds !== W'(15)) $display("FAIL timeout_err: leds=%b required 1111", leds);
    else n_pass++;
    press(0, 0, 1);
    n_total++;
    if (leds !== W'(0)) $display("FAIL timeout_recover: leds=%b required 0000", leds);
    else n_pass++;
    dp_delay = 4;
  endtask

  task automatic test_reset_mid_run();
    bit found;
    do_reset();
    dp_delay = 6;
    repeat (6) press(1, 0, 0);
    press(0, 0, 1);
    repeat (2) press(1, 0, 0);
    ok_until_start(found);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (!found || leds !== W'(0) || dp.dp_num !== W'(0) || dp.dp_start !== 1'b0)
      $display("FAIL reset_mid_run: seen=%0d leds=%b num=%0d start=%b required 1 0000 0 0",
               found, leds, dp.dp_num, dp.dp_start);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if (leds !== W'(0)) $display("FAIL late_done_ignored: leds=%b required 0000", leds);
    else n_pass++;
    press(1, 0, 0);
    n_total++;
    if (leds !== W'(1)) $display("FAIL after_reset_in_num: leds=%b required 0001", leds);
    else n_pass++;
    dp_delay = 4;
  endtask

  task automatic test_random();
    int e, num, den, s0, r;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int op = 0; op < 2; op++) begin
        e = 0;
        for (int k = $urandom_range(7, 2); k > 0; k--) begin
          r = $urandom_range(2, 0);
          press(r == 0 || r == 2, r == 1 || r == 2, 0);
          if (r == 0) e = (e + 1) % 16;
          else if (r == 1) e = (e + 15) % 16;
        end
        n_total++;
        if (leds !== W'(e)) $display("FAIL rand%0d_edit%0d: leds=%b required %b", it, op, leds, W'(e));
        else n_pass++;
        if (op == 0) begin
          num = e;
          press(0, 0, 1);
        end else den = e;
      end
      dp_delay = $urandom_range(8, 1);
      s0 = start_cnt;
      press(0, 0, 1);
      repeat (20) @(negedge clk);
      if (den == 0) begin
        n_total++;
        if (leds !== W'(15) || start_cnt != s0)
          $display("FAIL rand%0d_err: leds=%b starts=%0d required 1111 0", it, leds, start_cnt - s0);
        else n_pass++;
      end else begin
        n_total++;
        if (start_cnt - s0 != 1 || cap_num !== W'(num) || cap_den !== W'(den) || leds !== W'(num / den))
          $display("FAIL rand%0d_quot: starts=%0d num=%0d den=%0d leds=%b required 1 %0d %0d %b",
                   it, start_cnt - s0, cap_num, cap_den, leds, num, den, W'(num / den));
        else n_pass++;
`ifdef DIV_REM_DISPLAY_EN
        press(0, 0, 1);
        n_total++;
        if (leds !== W'(num % den)) $display("FAIL rand%0d_rem: leds=%b required %b", it, leds, W'(num % den));
        else n_pass++;
`endif
      end
      press(0, 0, 1);
      n_total++;
      if (leds !== W'(0)) $display("FAIL rand%0d_to_num: leds=%b required 0000", it, leds);
      else n_pass++;
    end
    dp_delay = 4;
  endtask

  initial begin
    test_reset();
    test_edit();
    test_wrap();
    test_simultaneous();
    test_divide();
    test_den_zero();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter: W, 4, operand/result width.
REQ-002 Parameter: TIMEOUT, 16, max cycles in RUN awaiting dp_done.
REQ-003 Port: clk  in  1  system clock, all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: up / down / ok  in  1 each  raw pushbuttons, active-low (1 = released), asynchronous to clk.
REQ-006 Port: leds  out  W  operand/result/status display.
REQ-007 Port: dp_start  out  1  one-cycle pulse launching the divider datapath.
REQ-008 Port: dp_num, dp_den  out  W each  operands to datapath.
REQ-009 Port: dp_done  in  1  datapath completion, sampled only in RUN.
REQ-010 Port: dp_quot, dp_rem  in  W each  results, valid in the cycle dp_done=1.

Function
REQ-011 Each button SHALL pass a 2-FF synchronizer; a press event SHALL be a one-cycle pulse on a synchronized 1->0 transition.
REQ-012 States SHALL be NUM, DEN, RUN, QUOT, REM, ERR.
REQ-013 NUM/DEN: up press SHALL increment the edit register mod 2^W (15->0); down press SHALL decrement (0->15).
REQ-014 Simultaneous up and down presses SHALL leave the edit register unchanged.
REQ-015 ok press SHALL take priority over up/down in the same cycle.
REQ-016 NUM + ok: edit register SHALL be latched to dp_num, edit register cleared to 0, -> DEN.
REQ-017 DEN + ok with edit=0: -> ERR, no dp_start.
REQ-018 DEN + ok with edit!=0: latch dp_den, assert dp_start in the next cycle for exactly one cycle, -> RUN.
REQ-019 dp_num/dp_den SHALL remain stable from dp_start until the next NUM/DEN latch.
REQ-020 RUN: all button presses ignored; on dp_done capture dp_quot/dp_rem, -> QUOT.
REQ-021 RUN: a cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT without dp_done, -> ERR.
REQ-022 dp_done outside RUN SHALL be ignored.
REQ-023 leds SHALL equal: edit register in NUM/DEN; 0000 in RUN; captured quotient in QUOT; captured remainder in REM; 1111 in ERR.
REQ-024 QUOT + ok: -> REM (see REQ-028). REM + ok: -> NUM. ERR + ok: -> NUM.
REQ-025 Every entry into NUM SHALL clear the edit register to 0.

Reset
REQ-026 rst=1 SHALL immediately force state NUM, edit register 0, leds 0000, dp_start 0, dp_num/dp_den 0, captured results 0, RUN counter 0, synchronizer flops 1 (released), in any state including RUN.
REQ-027 After rst deassertion no spurious press event SHALL occur while buttons stay released.

Configuration
REQ-028 Macro DIV_REM_DISPLAY_EN: defined -> QUOT + ok goes to REM; undefined -> REM state and remainder capture absent, QUOT + ok goes directly to NUM.

Structure
REQ-029 Package div_pkg SHALL hold the state enum typedef, W default and TIMEOUT default.
REQ-030 Sub-module btn_sync (2-FF sync + falling-edge pulse) SHALL be instantiated once per button.

Verification
REQ-031 Reset; 3 up presses -> leds 0011; 1 down press -> leds 0010.
REQ-032 In NUM at 0: down press -> leds 1111; up press -> leds 0000 (wrap both ways).
REQ-033 num=9, ok, den=2, ok; model returns dp_done after 4 cycles with quot=4 rem=1 -> exactly one dp_start with dp_num=9, dp_den=2; leds 0100; ok -> 0001 (macro defined); ok -> NUM, leds 0000.
REQ-034 den=0 + ok -> leds 1111, no dp_start pulse; ok -> NUM, leds 0000.
REQ-035 dp_done held 0 in RUN -> ERR (leds 1111) exactly TIMEOUT=16 cycles after RUN entry.
REQ-036 rst pulse mid-RUN -> leds 0000 within the same cycle, state NUM; dp_done arriving afterwards -> no state change.
